// File: rtl/y86_bus_mem.sv
// y86_bus_mem: zero-latency bus responder for the y86 core (RAM, console FIFO, status, loader)
// Ports:
//   clk, rst                       clock; synchronous active-high reset
//   bus_A/RE/WE/wdata -> bus_rdata core bus; read data is combinational, same cycle
//   ld_en/ld_addr/ld_data          byte loader for program preload
//   con_valid/con_data/con_ready   console FIFO head, popped on valid && ready
//   rd_count, wr_count             saturating transaction counters
//   err                            sticky flag for simultaneous read and write strobes
module y86_bus_mem #(
   parameter int          AW           = 12,
   parameter logic [31:0] CONSOLE_ADDR = 32'hFFFF_FF00,
   parameter logic [31:0] STATUS_ADDR  = 32'hFFFF_FF04,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   bus_A,
   input  logic          bus_RE,
   input  logic          bus_WE,
   input  logic [31:0]   bus_wdata,
   output logic [31:0]   bus_rdata,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [7:0]    ld_data,
   output logic          con_valid,
   output logic [7:0]    con_data,
   input  logic          con_ready,
   output logic [15:0]   rd_count,
   output logic [15:0]   wr_count,
   output logic          err
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int OW = PW + 1;
   logic [7:0]    mem [2**AW];
   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [7:0]    fifo_d [FIFO_DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [OW-1:0] occ_q, occ_d;
   logic          ovf_q, ovf_d, err_q, err_d;
   logic [15:0]   rd_q, rd_d, wr_q, wr_d;
   logic          sel_con, sel_stat, rd_ok, wr_ok, ram_we, push_req, push, pop;
   logic [AW-1:0] a;
   logic [31:0]   ram_word, status;
   always_comb begin
      a         = bus_A[AW-1:0];
      sel_con   = bus_A == CONSOLE_ADDR;
      sel_stat  = bus_A == STATUS_ADDR;
      rd_ok     = bus_RE & ~bus_WE;
      wr_ok     = bus_WE & ~bus_RE;
      ram_we    = wr_ok & ~sel_con & ~sel_stat;
      ram_word  = {mem[a + AW'(3)], mem[a + AW'(2)], mem[a + AW'(1)], mem[a]};
      status    = {wr_q, 6'b0, err_q, ovf_q, 5'b0, 3'(occ_q)};
      bus_rdata = !bus_RE ? 32'h0 : sel_con ? 32'h0 : sel_stat ? status : ram_word;
      pop       = (occ_q != '0) & con_ready;
      push_req  = wr_ok & sel_con;
      // a pop in the same cycle frees the slot the push needs
      push      = push_req & ((occ_q != OW'(FIFO_DEPTH)) | pop);
      fifo_d    = fifo_q;
      if (push) fifo_d[tail_q] = bus_wdata[7:0];
      head_d    = head_q + PW'(pop);
      tail_d    = tail_q + PW'(push);
      occ_d     = occ_q + OW'(push) - OW'(pop);
      ovf_d     = ovf_q | (push_req & ~push);
      err_d     = err_q | (bus_RE & bus_WE);
      rd_d      = (rd_ok && rd_q != 16'hFFFF) ? rd_q + 16'd1 : rd_q;
      wr_d      = (wr_ok && wr_q != 16'hFFFF) ? wr_q + 16'd1 : wr_q;
   end
   // RAM is never reset so a preloaded program survives rst; the bus write is
   // issued last so it overrides a loader write to the same byte
   always_ff @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      if (ram_we) for (int i = 0; i < 4; i++) mem[a + AW'(i)] <= bus_wdata[8*i +: 8];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_q <= '{default: '0};
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         ovf_q  <= 1'b0;
         err_q  <= 1'b0;
         rd_q   <= '0;
         wr_q   <= '0;
      end else begin
         fifo_q <= fifo_d;
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
         ovf_q  <= ovf_d;
         err_q  <= err_d;
         rd_q   <= rd_d;
         wr_q   <= wr_d;
      end
   end
   assign con_valid = occ_q != '0;
   assign con_data  = fifo_q[head_q];
   assign rd_count  = rd_q;
   assign wr_count  = wr_q;
   assign err       = err_q;
endmodule

// File: tb/tb_y86_bus_mem.sv
// tb_y86_bus_mem: directed self-checking bench for y86_bus_mem
module tb_y86_bus_mem;
   localparam logic [31:0] CON  = 32'hFFFF_FF00;
   localparam logic [31:0] STAT = 32'hFFFF_FF04;
   logic        clk = 0;
   logic        rst = 0;
   logic [31:0] bus_A = 0;
   logic        bus_RE = 0;
   logic        bus_WE = 0;
   logic [31:0] bus_wdata = 0;
   logic [31:0] bus_rdata;
   logic        ld_en = 0;
   logic [11:0] ld_addr = 0;
   logic [7:0]  ld_data = 0;
   logic        con_valid;
   logic [7:0]  con_data;
   logic        con_ready = 0;
   logic [15:0] rd_count, wr_count;
   logic        err;
   int          checks = 0;
   int          errors = 0;

   y86_bus_mem dut (
      .clk(clk), .rst(rst), .bus_A(bus_A), .bus_RE(bus_RE), .bus_WE(bus_WE),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .ld_en(ld_en), .ld_addr(ld_addr),
      .ld_data(ld_data), .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
      .rd_count(rd_count), .wr_count(wr_count), .err(err)
   );

   always #5 clk = ~clk;

   // inputs change at the falling edge; outputs are sampled 1 time unit later
   task automatic drive(input logic re, input logic we, input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      bus_RE = re;
      bus_WE = we;
      bus_A = a;
      bus_wdata = wd;
      ld_en = 0;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 32'h0, 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      bus_RE = 0;
      bus_WE = 0;
      ld_en = 0;
      @(negedge clk);
      rst = 0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL reset_con_valid: got %b want 0", con_valid); end
      checks++; if (rd_count !== 16'h0) begin errors++; $display("FAIL reset_rd_count: got %h want 0000", rd_count); end
      checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL reset_wr_count: got %h want 0000", wr_count); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
      checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL idle_rdata: got %h want 00000000", bus_rdata); end
   endtask

   task automatic test_loader();
      logic [7:0] bytes [4] = '{8'h8B, 8'h46, 8'h04, 8'h01};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ld_en = 1;
         ld_addr = 12'(i);
         ld_data = bytes[i];
      end
      drive(1, 0, 32'h0, 32'h0);
      checks++; if (bus_rdata !== 32'h0104468B) begin errors++; $display("FAIL loader_read: got %h want 0104468B", bus_rdata); end
      idle();
      checks++; if (rd_count !== 16'd1) begin errors++; $display("FAIL loader_rd_count: got %0d want 1", rd_count); end
   endtask

   task automatic test_wrap();
      drive(0, 1, 32'hFFE, 32'hAABBCCDD);
      drive(1, 0, 32'hFFE, 32'h0);
      checks++; if (bus_rdata !== 32'hAABBCCDD) begin errors++; $display("FAIL wrap_read: got %h want AABBCCDD", bus_rdata); end
      drive(1, 0, 32'h0, 32'h0);
      checks++; if (bus_rdata !== 32'h0104AABB) begin errors++; $display("FAIL wrap_low: got %h want 0104AABB", bus_rdata); end
      idle();
      checks++; if (rd_count !== 16'd3 || wr_count !== 16'd1) begin errors++; $display("FAIL wrap_counts: got rd=%0d wr=%0d want rd=3 wr=1", rd_count, wr_count); end
   endtask

   task automatic test_loader_collision();
      drive(0, 1, 32'h20, 32'h04030201);
      ld_en = 1; ld_addr = 12'h20; ld_data = 8'hEE;
      drive(1, 0, 32'h20, 32'h0);
      checks++; if (bus_rdata !== 32'h04030201) begin errors++; $display("FAIL collide_bus_wins: got %h want 04030201", bus_rdata); end
      drive(0, 1, 32'h20, 32'h0D0C0B0A);
      ld_en = 1; ld_addr = 12'h24; ld_data = 8'h77;
      drive(1, 0, 32'h21, 32'h0);
      checks++; if (bus_rdata !== 32'h770D0C0B) begin errors++; $display("FAIL collide_loader_kept: got %h want 770D0C0B", bus_rdata); end
      idle();
   endtask

   task automatic test_console_overflow();
      logic [7:0] msg [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
      con_ready = 0;
      for (int i = 0; i < 5; i++) drive(0, 1, CON, {24'hFFFFFF, msg[i]});
      drive(1, 0, STAT, 32'h0);
      checks++; if (bus_rdata !== 32'h00080104) begin errors++; $display("FAIL overflow_status: got %h want 00080104", bus_rdata); end
      drive(1, 0, CON, 32'h0);
      checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL console_read_zero: got %h want 00000000", bus_rdata); end
      idle();
      con_ready = 1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (con_valid !== 1'b1 || con_data !== msg[i]) begin errors++; $display("FAIL drain_%0d: got valid=%b data=%h want valid=1 data=%h", i, con_valid, con_data, msg[i]); end
         idle();
      end
      checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got valid=%b want 0", con_valid); end
      con_ready = 0;
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp [4] = '{8'h62, 8'h63, 8'h64, 8'h65};
      do_reset();
      for (int i = 0; i < 4; i++) drive(0, 1, CON, 32'h61 + 32'(i));
      drive(0, 1, CON, 32'h65);
      con_ready = 1;
      drive(1, 0, STAT, 32'h0);
      con_ready = 0;
      checks++; if (bus_rdata !== 32'h00050004) begin errors++; $display("FAIL full_push_status: got %h want 00050004", bus_rdata); end
      idle();
      con_ready = 1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (con_valid !== 1'b1 || con_data !== exp[i]) begin errors++; $display("FAIL full_drain_%0d: got valid=%b data=%h want valid=1 data=%h", i, con_valid, con_data, exp[i]); end
         idle();
      end
      checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL full_drain_empty: got valid=%b want 0", con_valid); end
      con_ready = 0;
   endtask

   task automatic test_conflict();
      drive(0, 1, 32'h8, 32'hCAFEF00D);
      drive(1, 1, 32'h8, 32'h12345678);
      checks++; if (bus_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL conflict_rdata: got %h want CAFEF00D", bus_rdata); end
      idle();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL conflict_err: got %b want 1", err); end
      checks++; if (rd_count !== 16'd1 || wr_count !== 16'd6) begin errors++; $display("FAIL conflict_counts: got rd=%0d wr=%0d want rd=1 wr=6", rd_count, wr_count); end
      drive(1, 0, 32'h8, 32'h0);
      checks++; if (bus_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL conflict_ram_kept: got %h want CAFEF00D", bus_rdata); end
      drive(1, 0, STAT, 32'h0);
      checks++; if (bus_rdata !== 32'h00060200) begin errors++; $display("FAIL conflict_status: got %h want 00060200", bus_rdata); end
      idle();
   endtask

   task automatic test_saturate_and_reset();
      drive(1, 0, 32'h0, 32'h0);
      repeat (70000) @(negedge clk);
      idle();
      checks++; if (rd_count !== 16'hFFFF) begin errors++; $display("FAIL saturate_rd: got %h want FFFF", rd_count); end
      con_ready = 0;
      drive(0, 1, CON, 32'h7A);
      idle();
      checks++; if (con_valid !== 1'b1 || con_data !== 8'h7A) begin errors++; $display("FAIL pre_reset_push: got valid=%b data=%h want valid=1 data=7a", con_valid, con_data); end
      do_reset();
      checks++; if (rd_count !== 16'h0 || wr_count !== 16'h0 || err !== 1'b0) begin errors++; $display("FAIL mid_reset_clear: got rd=%h wr=%h err=%b want 0 0 0", rd_count, wr_count, err); end
      checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_fifo: got valid=%b want 0", con_valid); end
      drive(1, 0, 32'h0, 32'h0);
      checks++; if (bus_rdata !== 32'h0104AABB) begin errors++; $display("FAIL reset_ram_kept: got %h want 0104AABB", bus_rdata); end
      idle();
   endtask

   initial begin
      test_reset();
      test_loader();
      test_wrap();
      test_loader_collision();
      test_console_overflow();
      test_full_push_pop();
      test_conflict();
      test_saturate_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/y86_bus_mem.md
Name: y86_bus_mem

Overview:
- Memory-side responder for the y86 sequential core's bus: the core is the initiator and this block is the responder.
- Byte-addressable little-endian RAM with 32-bit unaligned reads and writes.
- Memory-mapped console output FIFO and status register.
- Byte loader port so the bench can preload a program before releasing the core.
- Read data is returned in the same cycle as the request, because the core samples it at the end of its fetch/load cycle.

Parameters:
AW, 12, RAM byte-address width; RAM size is 2**AW bytes; RAM addresses wrap modulo 2**AW.
CONSOLE_ADDR, 32'hFFFF_FF00, write-only console data port (byte in bits [7:0]).
STATUS_ADDR, 32'hFFFF_FF04, read-only status word.
FIFO_DEPTH, 4, console FIFO entries (power of 2).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
bus_A  in  32  byte address from core
bus_RE  in  1  read strobe
bus_WE  in  1  write strobe
bus_wdata  in  32  write data (core's bus_out)
bus_rdata  out  32  read data (core's bus_in)
ld_en  in  1  loader byte write enable
ld_addr  in  AW  loader byte address
ld_data  in  8  loader byte
con_valid  out  1  console FIFO head valid
con_data  out  8  console FIFO head byte
con_ready  in  1  consumer accepts head
rd_count  out  16  completed read transactions, saturating
wr_count  out  16  completed write transactions, saturating
err  out  1  sticky protocol error

Behaviour:
- Reset: con_valid=0, FIFO occupancy=0, overflow=0, err=0, rd_count=0, wr_count=0. RAM contents are not cleared; the loader relies on this.
- Address decode: bus_A==CONSOLE_ADDR selects console; bus_A==STATUS_ADDR selects status; any other address selects RAM at byte bus_A[AW-1:0].
- RAM read (combinational, zero latency):
  - While bus_RE=1 and RAM is selected, bus_rdata = {m[a+3], m[a+2], m[a+1], m[a]}.
  - Each byte index is computed modulo 2**AW, so a read at 2**AW-2 wraps to bytes 0 and 1.
- Status read: bus_rdata = {wr_count, 6'b0, err, overflow, 5'b0, occupancy[2:0]}. The value is taken before this cycle's updates.
- Console read: returns 0.
- bus_RE=0: bus_rdata=0.
- RAM write (on the posedge with bus_WE=1, RAM selected): m[a+i] <= bus_wdata[8i+7:8i] for i=0..3, with the same modulo wrap.
- Console write: pushes bus_wdata[7:0].
  - The push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky until rst).
- Status write: ignored, but still counted.
- FIFO:
  - con_valid = (occupancy != 0); con_data = head byte.
  - A pop occurs on a posedge with con_valid && con_ready.
  - A simultaneous push and pop leaves occupancy unchanged.
  - FIFO order is preserved.
- Loader: ld_en writes ld_data to m[ld_addr] on the posedge.
  - If a bus RAM write in the same cycle covers the same byte, the bus data wins.
  - Loader bytes not covered by the bus write are still written.
- bus_RE and bus_WE both 1:
  - err is set (sticky).
  - No RAM or FIFO write occurs.
  - bus_rdata is still driven per the read rules.
  - Neither counter increments.
- Counters:
  - rd_count increments on each cycle with bus_RE=1 only; wr_count on each cycle with bus_WE=1 only.
  - Both count RAM and MMIO accesses.
  - Both saturate at 16'hFFFF.
  - A multi-cycle strobe counts once per cycle.
- rst asserted mid-operation: FIFO contents are discarded and flags and counters clear next edge; RAM is untouched.

Test Plan:
- Load bytes 0x8B,0x46,0x04,0x01 at 0..3 via loader; bus_RE=1, bus_A=0 -> bus_rdata=32'h0104468B in the same cycle, with rd_count=1 after the edge.
- Write 32'hAABBCCDD at bus_A=2**AW-2, then read at 2**AW-2 -> 32'hAABBCCDD; read at 0 -> low 16 bits 16'hAABB.
- With con_ready=0, write 'H','e','l','l','o' to CONSOLE_ADDR -> occupancy=4 and overflow=1; set con_ready=1 -> bytes H,e,l,l drained in order, then con_valid=0.
- FIFO full with con_ready=1 and a console write in the same cycle -> byte accepted, occupancy stays 4, overflow stays 0.
- bus_RE=bus_WE=1 at RAM address 8 with bus_wdata=32'h12345678 -> err=1, m[8..11] unchanged, counters unchanged; status read shows bit 9 set.
- 70000 consecutive read cycles -> rd_count=16'hFFFF; assert rst -> counters 0, err 0, RAM contents retained.
